riscv_base_regfile: RTL and testbench

Integer register file for the RV32I base core: 32 x 32-bit architectural registers x0..x31.
- Two asynchronous (combinational) read ports, A and B, feed the decode/execute stage.
- One synchronous write port is driven by writeback.
- x0 is hardwired to zero.
- Writing to x0 is the pipeline's "no write" encoding, so there is no separate write-enable.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_regfile_xilinx_ram.sv | 30 +++
 rtl/riscv_base_regfile.sv | 78 +++++++
 tb/tb_riscv_base_regfile.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I integer register-file constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    function automatic logic is_reg_zero(input logic [REG_IDX_W-1:0] idx);
        return (idx == REG_ZERO);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/riscv_regfile_xilinx_ram.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile_xilinx_ram
// Description : 32x32 single-write / single-async-read distributed-RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_regfile_xilinx_ram
    import riscv_pkg::*;
(
    input  wire logic                 i_clk,
    input  wire logic                 i_we,
    input  wire logic [REG_IDX_W-1:0] i_waddr,
    input  wire logic [XLEN-1:0]      i_wdata,
    input  wire logic [REG_IDX_W-1:0] i_raddr,
    output logic      [XLEN-1:0]      o_rdata
);

    // No reset: LUTRAM contents come up as zero from device configuration.
    logic [XLEN-1:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : riscv_regfile_xilinx_ram
`default_nettype wire

// File: rtl/riscv_base_regfile.sv
`default_nettype none
// ============================================================================
// Module      : riscv_base_regfile
// Description : RV32I integer register file, 2 async read ports, 1 write port.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_base_regfile
    import riscv_pkg::*;
#(
    parameter int SUPPORT_REGFILE_XILINX = 0
)
(
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic [REG_IDX_W-1:0] rd0_i,
    input  wire logic [XLEN-1:0]      rd0_value_i,
    input  wire logic [REG_IDX_W-1:0] ra0_i,
    input  wire logic [REG_IDX_W-1:0] rb0_i,
    output logic      [XLEN-1:0]      ra0_value_o,
    output logic      [XLEN-1:0]      rb0_value_o
);

    // Index zero doubles as the "no write" encoding from writeback.
    logic            w_wr_en;
    logic [XLEN-1:0] w_ra_data;
    logic [XLEN-1:0] w_rb_data;

    assign w_wr_en = !is_reg_zero(rd0_i);

    generate
        if (SUPPORT_REGFILE_XILINX != 0) begin : g_xilinx
            riscv_regfile_xilinx_ram u_ram_a (
                .i_clk   (clk_i),
                .i_we    (w_wr_en),
                .i_waddr (rd0_i),
                .i_wdata (rd0_value_i),
                .i_raddr (ra0_i),
                .o_rdata (w_ra_data)
            );

            riscv_regfile_xilinx_ram u_ram_b (
                .i_clk   (clk_i),
                .i_we    (w_wr_en),
                .i_waddr (rd0_i),
                .i_wdata (rd0_value_i),
                .i_raddr (rb0_i),
                .o_rdata (w_rb_data)
            );
        end else begin : g_generic
            logic [XLEN-1:0] w_rf [NUM_REGS];

            assign w_rf[0] = '0;

            for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
                logic [XLEN-1:0] r_q;

                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        r_q <= '0;
                    end else if (w_wr_en && (rd0_i == REG_IDX_W'(gi))) begin
                        r_q <= rd0_value_i;
                    end
                end

                assign w_rf[gi] = r_q;
            end

            assign w_ra_data = w_rf[ra0_i];
            assign w_rb_data = w_rf[rb0_i];
        end
    endgenerate

    // No write-to-read forwarding: a same-cycle write shows up after the edge.
    assign ra0_value_o = is_reg_zero(ra0_i) ? '0 : w_ra_data;
    assign rb0_value_o = is_reg_zero(rb0_i) ? '0 : w_rb_data;

endmodule : riscv_base_regfile
`default_nettype wire

// File: tb/tb_riscv_base_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_base_regfile
// Description : Directed/random self-checking bench for riscv_base_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_base_regfile;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  rd0_i = 5'd0;
    logic [31:0] rd0_value_i = 32'h0;
    logic [4:0]  ra0_i = 5'd0;
    logic [4:0]  rb0_i = 5'd0;
    logic [31:0] ra0_value_o;
    logic [31:0] rb0_value_o;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [31:0] m_rf [32];
    logic [31:0] d    [32];

    riscv_base_regfile #(.SUPPORT_REGFILE_XILINX(0)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rd0_i       (rd0_i),
        .rd0_value_i (rd0_value_i),
        .ra0_i       (ra0_i),
        .rb0_i       (rb0_i),
        .ra0_value_o (ra0_value_o),
        .rb0_value_o (rb0_value_o)
    );

    always #5 clk = ~clk;

    // Architectural model: x1..x31 hold whatever was last written out of reset.
    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end

    always @(negedge rst_i) begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else if (rd0_i != 5'd0) begin
            m_rf[rd0_i] = rd0_value_i;
        end
    end

    function automatic logic [31:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : m_rf[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mid-cycle compare of both read ports against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_a", ra0_value_o, model_rd(ra0_i));
            chk("mon_b", rb0_value_o, model_rd(rb0_i));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_i = 1'b0;
        mon_en = 1'b1;
        // Writes presented during reset must be dropped.
        rd0_i = 5'd3; rd0_value_i = 32'hCAFEF00D;
        repeat (3) step();
        ra0_i = 5'd3; #1;
        chk("rst_hold_x3", ra0_value_o, 32'h0);
        rd0_i = 5'd0;
        rst_i = 1'b1;

        for (int i = 0; i < 32; i++) begin
            ra0_i = 5'(i); #1;
            chk("rst_sweep", ra0_value_o, 32'h0);
        end

        rd0_i = 5'd0; rd0_value_i = 32'hDEADBEEF; ra0_i = 5'd0;
        repeat (2) step();
        chk("x0_deadbeef", ra0_value_o, 32'h0);
        rd0_value_i = 32'hFFFFFFFF;
        repeat (2) step();
        chk("x0_ffffffff", ra0_value_o, 32'h0);

        d[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            d[i] = $urandom;
            rd0_i = 5'(i); rd0_value_i = d[i]; ra0_i = 5'(i);
            step();
            chk("wr_rd", ra0_value_o, d[i]);
        end
        rd0_i = 5'd0;

        for (int a = 1; a <= 5; a++) begin
            for (int b = 26; b <= 31; b++) begin
                ra0_i = 5'(a); rb0_i = 5'(b); #1;
                chk("dual_a", ra0_value_o, d[a]);
                chk("dual_b", rb0_value_o, d[b]);
            end
        end

        rd0_i = 5'd10; rd0_value_i = 32'h12345678; ra0_i = 5'd5; rb0_i = 5'd15;
        step();
        chk("diff_a", ra0_value_o, d[5]);
        chk("diff_b", rb0_value_o, d[15]);
        rd0_i = 5'd0; ra0_i = 5'd10; #1;
        chk("diff_x10", ra0_value_o, 32'h12345678);

        rd0_i = 5'd7; rd0_value_i = 32'hAAAA5555;
        step();
        rd0_i = 5'd7; rd0_value_i = 32'h0F0F0F0F; ra0_i = 5'd7; rb0_i = 5'd10; #1;
        chk("rdw_before", ra0_value_o, 32'hAAAA5555);
        step();
        chk("rdw_after", ra0_value_o, 32'h0F0F0F0F);

        // Reset lands mid-cycle with a write pending: clear is immediate, write lost.
        rd0_value_i = 32'h55555555;
        #2 rst_i = 1'b0; #1;
        chk("async_rst_a", ra0_value_o, 32'h0);
        chk("async_rst_b", rb0_value_o, 32'h0);
        step();
        chk("rst_write_lost", ra0_value_o, 32'h0);
        rd0_i = 5'd0;
        rst_i = 1'b1;
        rd0_i = 5'd9; rd0_value_i = 32'h00C0FFEE; ra0_i = 5'd9;
        step();
        chk("first_write", ra0_value_o, 32'h00C0FFEE);

        for (int n = 0; n < 100; n++) begin
            rd0_i = 5'($urandom_range(0, 31));
            rd0_value_i = $urandom;
            ra0_i = 5'($urandom_range(0, 31));
            rb0_i = 5'($urandom_range(0, 31));
            if (n % 8 == 0) ra0_i = 5'd0;
            if (n % 11 == 0) begin rd0_i = 5'd0; rd0_value_i = 32'hDEADBEEF; end
            #1;
            if (ra0_i == 5'd0) chk("stress_x0_a", ra0_value_o, 32'h0);
            if (rb0_i == 5'd0) chk("stress_x0_b", rb0_value_o, 32'h0);
            step();
        end

        rd0_i = 5'd31; rd0_value_i = 32'hFFFFFFFF; ra0_i = 5'd31; rb0_i = 5'd31;
        step();
        chk("x31_ones_a", ra0_value_o, 32'hFFFFFFFF);
        chk("x31_ones_b", rb0_value_o, 32'hFFFFFFFF);
        rd0_value_i = 32'h00000000;
        step();
        chk("x31_zero", ra0_value_o, 32'h00000000);
        rd0_i = 5'd0;
        step();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_riscv_base_regfile
`default_nettype wire
